// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request, with
// store lane steering, load extraction/extension and alignment/funct3 checks.
module lsu #(
   parameter int W_SIZE = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [W_SIZE-1:0] addr,
   input  logic [W_SIZE-1:0] wdata,
   input  logic [2:0]        funct3,
   input  logic              is_store,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [W_SIZE-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [W_SIZE-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [W_SIZE-1:0] mem_rdata,
   output logic              resp_valid,
   output logic [W_SIZE-1:0] resp_data,
   output logic              resp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [W_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_we_q, mem_we_d;
   logic [W_SIZE-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              is_store_q, is_store_d;
   logic [W_SIZE-1:0] resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;

   logic              accept;
   logic              req_err;
   logic [3:0]        store_we;
   logic [W_SIZE-1:0] store_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [W_SIZE-1:0] load_data;

   assign accept = (state_q == IDLE) && req_valid;

   always_comb begin
      req_err = 1'b0;
      case (funct3)
         3'b011, 3'b110, 3'b111: req_err = 1'b1;
         3'b001, 3'b101:         req_err = addr[0];
         3'b010:                 req_err = (addr[1:0] != 2'b00);
         default:                req_err = 1'b0;
      endcase
   end

   // Store data is replicated across lanes; the enables pick the live lanes.
   always_comb begin
      store_we   = 4'b1111;
      store_data = wdata;
      case (funct3[1:0])
         2'b00: begin
            store_we   = 4'b0001 << addr[1:0];
            store_data = {4{wdata[7:0]}};
         end
         2'b01: begin
            store_we   = 4'b0011 << addr[1:0];
            store_data = {2{wdata[15:0]}};
         end
         default: begin
            store_we   = 4'b1111;
            store_data = wdata;
         end
      endcase
   end

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h000000, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0000, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_we_q    <= 4'b0000;
         mem_wdata_q <= '0;
         off_q       <= 2'b00;
         funct3_q    <= 3'b000;
         is_store_q  <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         off_q       <= off_d;
         funct3_q    <= funct3_d;
         is_store_q  <= is_store_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid)  state_d = req_err ? RESP : REQ;
         REQ:     if (mem_gnt)    state_d = is_store_q ? RESP : WAIT;
         WAIT:    if (mem_rvalid) state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
      off_d       = off_q;
      funct3_d    = funct3_q;
      is_store_d  = is_store_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      if (accept) begin
         mem_addr_d  = {addr[W_SIZE-1:2], 2'b00};
         mem_we_d    = is_store ? store_we : 4'b0000;
         mem_wdata_d = is_store ? store_data : '0;
         off_d       = addr[1:0];
         funct3_d    = funct3;
         is_store_d  = is_store;
         resp_data_d = '0;
         resp_err_d  = req_err;
      end else if ((state_q == WAIT) && mem_rvalid) begin
         resp_data_d = load_data;
      end
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      mem_req    = (state_q == REQ);
      resp_valid = (state_q == RESP);
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign resp_data = resp_data_q;
   assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: stores, loads, error cases, async reset and
// back-to-back requests, each compared against hand-computed values.
module tb_lsu;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic        is_store;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;

   int checks;
   int passes;

   lsu #(.W_SIZE(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .addr       (addr),
      .wdata      (wdata),
      .funct3     (funct3),
      .is_store   (is_store),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one load: gnt after gnt_delay REQ cycles, rvalid the cycle after gnt.
   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                          input int gnt_delay, output logic [31:0] data, output logic err,
                          output int lat, output int req_cycles, output logic [31:0] addr_seen,
                          output logic [3:0] we_seen, output logic timeout);
      int guard;
      req_valid = 1'b1; addr = a; funct3 = f3; is_store = 1'b0; wdata = 32'h0;
      step();
      req_valid = 1'b0;
      lat = 1; req_cycles = 0; timeout = 1'b0; guard = 0;
      addr_seen = mem_addr; we_seen = mem_we;
      while (mem_req === 1'b1 && guard < 20) begin
         req_cycles++;
         mem_gnt = (req_cycles > gnt_delay);
         step();
         lat++; guard++;
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = rd;
      step();
      lat++;
      mem_rvalid = 1'b0;
      guard = 0;
      while (resp_valid !== 1'b1 && guard < 20) begin
         step();
         lat++; guard++;
      end
      if (guard >= 20) timeout = 1'b1;
      data = resp_data; err = resp_err;
      step();
      $display("load f3=%03b addr=%08h rdata=%08h -> data=%08h err=%0b lat=%0d",
               f3, a, rd, data, err, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%0b exp=1", req_ready); else passes++;
      checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req got=%0b exp=0", mem_req); else passes++;
      checks++; if (mem_we !== 4'b0000) $display("FAIL rst_mem_we got=%04b exp=0000", mem_we); else passes++;
      checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%08h exp=0", mem_addr); else passes++;
      checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got=%08h exp=0", mem_wdata); else passes++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%0b exp=0", resp_valid); else passes++;
      checks++; if (resp_data !== 32'h0) $display("FAIL rst_resp_data got=%08h exp=0", resp_data); else passes++;
      checks++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got=%0b exp=0", resp_err); else passes++;
      step(); step();
      rst_n = 1'b1;
      step();
      $display("reset released");
   endtask

   task automatic test_sb();
      req_valid = 1'b1; addr = 32'h0000_1003; wdata = 32'h0000_00A5; funct3 = 3'b000; is_store = 1'b1;
      checks++; if (req_ready !== 1'b1) $display("FAIL sb_ready got=%0b exp=1", req_ready); else passes++;
      step();
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1) $display("FAIL sb_mem_req got=%0b exp=1", mem_req); else passes++;
      checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL sb_mem_addr got=%08h exp=00001000", mem_addr); else passes++;
      checks++; if (mem_we !== 4'b1000) $display("FAIL sb_mem_we got=%04b exp=1000", mem_we); else passes++;
      checks++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_mem_wdata got=%08h exp=a5a5a5a5", mem_wdata); else passes++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL sb_early_resp got=%0b exp=0", resp_valid); else passes++;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      checks++; if (resp_valid !== 1'b1) $display("FAIL sb_resp_valid got=%0b exp=1", resp_valid); else passes++;
      checks++; if (resp_err !== 1'b0) $display("FAIL sb_resp_err got=%0b exp=0", resp_err); else passes++;
      checks++; if (mem_req !== 1'b0) $display("FAIL sb_mem_req_resp got=%0b exp=0", mem_req); else passes++;
      step();
      checks++; if (resp_valid !== 1'b0) $display("FAIL sb_resp_pulse got=%0b exp=0", resp_valid); else passes++;
      checks++; if (req_ready !== 1'b1) $display("FAIL sb_ready_after got=%0b exp=1", req_ready); else passes++;
      $display("store SB addr=00001003 wdata=000000a5 done");
   endtask

   task automatic test_sh_sw();
      // SH at offset 2 then SW, both with immediate gnt.
      req_valid = 1'b1; addr = 32'h0000_1102; wdata = 32'hFFFF_BEEF; funct3 = 3'b001; is_store = 1'b1;
      step();
      req_valid = 1'b0;
      checks++; if (mem_we !== 4'b1100) $display("FAIL sh_mem_we got=%04b exp=1100", mem_we); else passes++;
      checks++; if (mem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_mem_wdata got=%08h exp=beefbeef", mem_wdata); else passes++;
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) $display("FAIL sh_resp got=%0b/%0b exp=1/0", resp_valid, resp_err); else passes++;
      step();
      req_valid = 1'b1; addr = 32'h0000_1104; wdata = 32'h1234_5678; funct3 = 3'b010; is_store = 1'b1;
      step();
      req_valid = 1'b0;
      checks++; if (mem_we !== 4'b1111) $display("FAIL sw_mem_we got=%04b exp=1111", mem_we); else passes++;
      checks++; if (mem_wdata !== 32'h1234_5678) $display("FAIL sw_mem_wdata got=%08h exp=12345678", mem_wdata); else passes++;
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      checks++; if (resp_valid !== 1'b1) $display("FAIL sw_resp got=%0b exp=1", resp_valid); else passes++;
      step();
      $display("store SH addr=00001102 and SW addr=00001104 done");
   endtask

   task automatic test_lb_lbu();
      logic [31:0] d, a_seen; logic e, to; logic [3:0] we_seen; int lat, rc;
      do_load(3'b000, 32'h0000_2001, 32'h0000_80FF, 2, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (to) $display("FAIL lb_timeout got=no_resp exp=resp"); else passes++;
      checks++; if (d !== 32'hFFFF_FF80) $display("FAIL lb_data got=%08h exp=ffffff80", d); else passes++;
      checks++; if (e !== 1'b0) $display("FAIL lb_err got=%0b exp=0", e); else passes++;
      checks++; if (rc !== 3) $display("FAIL lb_req_cycles got=%0d exp=3", rc); else passes++;
      checks++; if (lat !== 5) $display("FAIL lb_latency got=%0d exp=5", lat); else passes++;
      checks++; if (a_seen !== 32'h0000_2000) $display("FAIL lb_mem_addr got=%08h exp=00002000", a_seen); else passes++;
      checks++; if (we_seen !== 4'b0000) $display("FAIL lb_mem_we got=%04b exp=0000", we_seen); else passes++;
      do_load(3'b100, 32'h0000_2001, 32'h0000_80FF, 0, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'h0000_0080) $display("FAIL lbu_data got=%08h exp=00000080", d); else passes++;
      checks++; if (lat !== 3) $display("FAIL lbu_latency got=%0d exp=3", lat); else passes++;
   endtask

   task automatic test_lh_lw();
      logic [31:0] d, a_seen; logic e, to; logic [3:0] we_seen; int lat, rc;
      do_load(3'b001, 32'h0000_3002, 32'h8001_1234, 0, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'hFFFF_8001) $display("FAIL lh_data got=%08h exp=ffff8001", d); else passes++;
      do_load(3'b101, 32'h0000_3002, 32'h8001_1234, 1, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'h0000_8001) $display("FAIL lhu_data got=%08h exp=00008001", d); else passes++;
      checks++; if (lat !== 4) $display("FAIL lhu_latency got=%0d exp=4", lat); else passes++;
      do_load(3'b010, 32'h0000_3000, 32'h8001_1234, 0, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'h8001_1234) $display("FAIL lw_data got=%08h exp=80011234", d); else passes++;
      do_load(3'b001, 32'h0000_3000, 32'h8001_9234, 0, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'hFFFF_9234) $display("FAIL lh_low_data got=%08h exp=ffff9234", d); else passes++;
      do_load(3'b000, 32'h0000_3000, 32'h8001_1234, 0, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'h0000_0034) $display("FAIL lb0_data got=%08h exp=00000034", d); else passes++;
      do_load(3'b000, 32'h0000_3003, 32'h8001_1234, 0, d, e, lat, rc, a_seen, we_seen, to);
      checks++; if (d !== 32'hFFFF_FF80) $display("FAIL lb3_data got=%08h exp=ffffff80", d); else passes++;
   endtask

   task automatic test_errors();
      logic [2:0]  f3_tab [4] = '{3'b010, 3'b001, 3'b011, 3'b101};
      logic [31:0] a_tab  [4] = '{32'h0000_4002, 32'h0000_4001, 32'h0000_4000, 32'h0000_4003};
      logic        st_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; addr = a_tab[i]; funct3 = f3_tab[i]; is_store = st_tab[i]; wdata = 32'hFFFF_FFFF;
         step();
         req_valid = 1'b0;
         checks++; if (mem_req !== 1'b0) $display("FAIL err%0d_mem_req got=%0b exp=0", i, mem_req); else passes++;
         checks++; if (resp_valid !== 1'b1) $display("FAIL err%0d_resp_valid got=%0b exp=1", i, resp_valid); else passes++;
         checks++; if (resp_err !== 1'b1) $display("FAIL err%0d_resp_err got=%0b exp=1", i, resp_err); else passes++;
         checks++; if (resp_data !== 32'h0) $display("FAIL err%0d_resp_data got=%08h exp=0", i, resp_data); else passes++;
         step();
         checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) $display("FAIL err%0d_after got=%0b/%0b exp=0/0", i, mem_req, resp_valid); else passes++;
         $display("error op f3=%03b addr=%08h store=%0b done", f3_tab[i], a_tab[i], st_tab[i]);
      end
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1; addr = 32'h0000_5000; funct3 = 3'b010; is_store = 1'b0;
      step();
      req_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL mrst_req_ready got=%0b exp=1", req_ready); else passes++;
      checks++; if (mem_addr !== 32'h0) $display("FAIL mrst_mem_addr got=%08h exp=0", mem_addr); else passes++;
      checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) $display("FAIL mrst_ctrl got=%0b/%0b exp=0/0", mem_req, resp_valid); else passes++;
      step();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0001;
      step();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL mrst_stale%0d got=%0b/%0b exp=0/1", i, resp_valid, req_ready); else passes++;
         step();
      end
      req_valid = 1'b1; addr = 32'h0000_5004; wdata = 32'h0BAD_F00D; funct3 = 3'b010; is_store = 1'b1;
      step();
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5004) $display("FAIL mrst_next_req got=%0b/%08h exp=1/00005004", mem_req, mem_addr); else passes++;
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) $display("FAIL mrst_next_resp got=%0b/%0b exp=1/0", resp_valid, resp_err); else passes++;
      step();
      $display("reset during WAIT then SW addr=00005004 done");
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; addr = 32'h0000_6000; wdata = 32'hDEAD_BEEF; funct3 = 3'b010; is_store = 1'b1;
      step();
      addr = 32'h0000_6004; wdata = 32'h0; is_store = 1'b0;
      checks++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_req got=%0b exp=0", req_ready); else passes++;
      checks++; if (mem_we !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL b2b_sw got=%04b/%08h exp=1111/deadbeef", mem_we, mem_wdata); else passes++;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL b2b_resp1 got=%0b/%0b exp=1/0", resp_valid, req_ready); else passes++;
      step();
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL b2b_idle got=%0b/%0b/%0b exp=1/0/0", req_ready, resp_valid, mem_req); else passes++;
      step();
      req_valid = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6004 || mem_we !== 4'b0000) $display("FAIL b2b_lw_req got=%0b/%08h/%04b exp=1/00006004/0000", mem_req, mem_addr, mem_we); else passes++;
      mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
      checks++; if (req_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL b2b_wait got=%0b/%0b exp=0/0", req_ready, mem_req); else passes++;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; step(); mem_rvalid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE_F00D) $display("FAIL b2b_resp2 got=%0b/%08h exp=1/cafef00d", resp_valid, resp_data); else passes++;
      step();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_end got=%0b/%0b exp=0/1", resp_valid, req_ready); else passes++;
      $display("back-to-back SW addr=00006000 then LW addr=00006004 done");
   endtask

   initial begin
      checks = 0; passes = 0;
      rst_n = 1'b0; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0; funct3 = 3'b000; is_store = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      test_reset();
      test_sb();
      test_sh_sw();
      test_lb_lbu();
      test_lh_lw();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
